// File: rtl/sort_result_checker.sv
// sort_result_checker: 2-entry skid-buffered Avalon-ST pass-through
// that grades every packet in flight (length, ordering, framing).
//
// Ports
//   clk_i, srst_i            clock, async active-high reset
//   snk_*                    Avalon-ST sink (snk_ready_o registered)
//   src_*                    Avalon-ST source (head of skid buffer)
//   pkt_done_o               1-cycle pulse when result fields update
//   pkt_len_o                beats in last packet (saturating)
//   order_err_o              last packet had a descending pair
//   framing_err_o            last packet had a framing violation
//   pkt_cnt_o, err_cnt_o     saturating packet / error counters
module sort_result_checker #(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 256,
  localparam int LW          = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              pkt_done_o,
  output logic [LW-1:0]     pkt_len_o,
  output logic              order_err_o,
  output logic              framing_err_o,
  output logic [31:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PKT  = 1'b1;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] ONE_LEN = LW'(1);

  typedef struct packed {
    logic [LW-1:0] len;
    logic          ord;
    logic          frm;
  } res_t;

  // ---------------- skid buffer ----------------

  logic              acc;
  logic              dlv;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [DWIDTH-1:0] skid_data;
  logic              skid_sop;
  logic              skid_eop;
  logic              head_in;
  logic              head_skid;
  logic              skid_ld;

  assign acc         = snk_valid_i & snk_ready_o;
  assign dlv         = src_valid_o & src_ready_i;
  assign src_valid_o = (cnt != 2'd0);
  assign cnt_nxt     = cnt + {1'b0, acc} - {1'b0, dlv};

  // The head register takes the new beat when it is (or becomes)
  // empty of older data; otherwise the beat parks in the skid slot.
  assign head_in   = acc &
                     ((cnt == 2'd0) |
                      ((cnt == 2'd1) & dlv));
  assign head_skid = dlv & (cnt == 2'd2);
  assign skid_ld   = acc &
                     (((cnt == 2'd1) & ~dlv) |
                      (cnt == 2'd2));

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt                 <= 2'd0;
      snk_ready_o         <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      skid_data           <= '0;
      skid_sop            <= 1'b0;
      skid_eop            <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      // Looking at next occupancy keeps the sink from ever
      // overrunning without a path from src_ready_i.
      snk_ready_o <= ~cnt_nxt[1];
      if (head_in) begin
        src_data_o          <= snk_data_i;
        src_startofpacket_o <= snk_startofpacket_i;
        src_endofpacket_o   <= snk_endofpacket_i;
      end else if (head_skid) begin
        src_data_o          <= skid_data;
        src_startofpacket_o <= skid_sop;
        src_endofpacket_o   <= skid_eop;
      end
      if (skid_ld) begin
        skid_data <= snk_data_i;
        skid_sop  <= snk_startofpacket_i;
        skid_eop  <= snk_endofpacket_i;
      end
    end
  end

  // ---------------- packet checker ----------------

  logic [0:0]        st;
  logic [0:0]        st_nxt;
  logic [LW-1:0]     len;
  logic [LW-1:0]     len_nxt;
  logic [DWIDTH-1:0] prev;
  logic [DWIDTH-1:0] prev_nxt;
  logic              ord;
  logic              ord_nxt;
  logic              frm;
  logic              frm_nxt;
  logic              at_max;
  logic              stray;
  logic              c1_v;
  logic              c2_v;
  res_t              c1;
  res_t              c2;

  assign at_max = (len == MAX_LEN);

  always_comb begin
    st_nxt   = st;
    len_nxt  = len;
    prev_nxt = prev;
    ord_nxt  = ord;
    frm_nxt  = frm;
    stray    = 1'b0;
    c1_v     = 1'b0;
    c1       = '0;
    c2_v     = 1'b0;
    c2       = '0;
    if (acc) begin
      unique case (1'b1)
        (st == S_IDLE) && !snk_startofpacket_i: begin
          stray = 1'b1;
        end
        snk_startofpacket_i: begin
          // SOP inside a packet aborts it with a framing error.
          if (st == S_PKT) begin
            c1_v    = 1'b1;
            c1.len  = len;
            c1.ord  = ord;
            c1.frm  = 1'b1;
          end
          len_nxt  = ONE_LEN;
          prev_nxt = snk_data_i;
          ord_nxt  = 1'b0;
          frm_nxt  = 1'b0;
          if (snk_endofpacket_i) begin
            c2_v   = 1'b1;
            c2.len = ONE_LEN;
            st_nxt = S_IDLE;
          end else begin
            st_nxt = S_PKT;
          end
        end
        default: begin
          len_nxt  = at_max ? len : len + ONE_LEN;
          frm_nxt  = frm | at_max;
          ord_nxt  = ord | (snk_data_i < prev);
          prev_nxt = snk_data_i;
          if (snk_endofpacket_i) begin
            c1_v   = 1'b1;
            c1.len = len_nxt;
            c1.ord = ord_nxt;
            c1.frm = frm_nxt;
            st_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- result reporting ----------------

  // One result leaves per cycle. An abort that also closes a
  // single-beat packet yields two; the second waits in pend.
  logic pend_v;
  logic pend_v_nxt;
  res_t pend;
  res_t pend_nxt;
  logic emit_v;
  res_t emit;

  always_comb begin
    emit_v     = 1'b0;
    emit       = '0;
    pend_v_nxt = 1'b0;
    pend_nxt   = pend;
    priority case (1'b1)
      pend_v: begin
        emit_v     = 1'b1;
        emit       = pend;
        pend_v_nxt = c1_v | c2_v;
        pend_nxt   = c1_v ? c1 : c2;
      end
      c1_v: begin
        emit_v     = 1'b1;
        emit       = c1;
        pend_v_nxt = c2_v;
        pend_nxt   = c2;
      end
      c2_v: begin
        emit_v = 1'b1;
        emit   = c2;
      end
      default: ;
    endcase
  end

  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_sat;

  assign err_inc = {1'b0, emit_v & (emit.ord | emit.frm)} +
                   {1'b0, stray};
  assign err_sum = {1'b0, err_cnt_o} + {15'd0, err_inc};
  assign err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      st            <= S_IDLE;
      len           <= '0;
      prev          <= '0;
      ord           <= 1'b0;
      frm           <= 1'b0;
      pend_v        <= 1'b0;
      pend          <= '0;
      pkt_done_o    <= 1'b0;
      pkt_len_o     <= '0;
      order_err_o   <= 1'b0;
      framing_err_o <= 1'b0;
      pkt_cnt_o     <= '0;
      err_cnt_o     <= '0;
    end else begin
      st         <= st_nxt;
      len        <= len_nxt;
      prev       <= prev_nxt;
      ord        <= ord_nxt;
      frm        <= frm_nxt;
      pend_v     <= pend_v_nxt;
      pend       <= pend_nxt;
      pkt_done_o <= emit_v;
      err_cnt_o  <= err_sat;
      if (emit_v) begin
        pkt_len_o     <= emit.len;
        order_err_o   <= emit.ord;
        framing_err_o <= emit.frm;
        if (pkt_cnt_o != 32'hFFFF_FFFF)
          pkt_cnt_o <= pkt_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sort_result_checker.sv
// tb_sort_result_checker: random and directed stimulus for
// sort_result_checker against a queue-based packet model.
module tb_sort_result_checker;

  localparam int DW   = 8;
  localparam int MAXL = 256;
  localparam int LW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i;
  logic          snk_endofpacket_i;
  logic          snk_valid_i;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          src_ready_i;
  logic          pkt_done_o;
  logic [LW-1:0] pkt_len_o;
  logic          order_err_o;
  logic          framing_err_o;
  logic [31:0]   pkt_cnt_o;
  logic [15:0]   err_cnt_o;

  always #5 clk = ~clk;

  sort_result_checker #(
    .DWIDTH      (DW),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .pkt_done_o          (pkt_done_o),
    .pkt_len_o           (pkt_len_o),
    .order_err_o         (order_err_o),
    .framing_err_o       (framing_err_o),
    .pkt_cnt_o           (pkt_cnt_o),
    .err_cnt_o           (err_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------

  typedef struct {
    int len;
    bit ord;
    bit frm;
  } m_res_t;

  m_res_t        res_q[$];
  logic [DW+1:0] beat_q[$];
  bit            m_in;
  int            m_len;
  int            m_prev;
  bit            m_ord;
  bit            m_frm;
  int            m_stray;
  bit            e_done;
  int            e_len;
  bit            e_ord;
  bit            e_frm;
  longint        e_pkt;
  longint        e_err;
  bit            rdy_ok;
  int            acc_total = 0;
  int            dlv_total = 0;

  function automatic void m_beat(input int d, input bit s,
                                 input bit e);
    m_res_t r;
    if (!m_in) begin
      if (!s) m_stray++;
      else if (e) begin
        r = '{1, 1'b0, 1'b0};
        res_q.push_back(r);
      end else begin
        m_in = 1; m_len = 1; m_prev = d;
        m_ord = 0; m_frm = 0;
      end
    end else if (s) begin
      r = '{m_len, m_ord, 1'b1};
      res_q.push_back(r);
      if (e) begin
        r = '{1, 1'b0, 1'b0};
        res_q.push_back(r);
        m_in = 0;
      end else begin
        m_len = 1; m_prev = d;
        m_ord = 0; m_frm = 0;
      end
    end else begin
      if (m_len >= MAXL) m_frm = 1;
      else m_len++;
      if (d < m_prev) m_ord = 1;
      m_prev = d;
      if (e) begin
        r = '{m_len, m_ord, m_frm};
        res_q.push_back(r);
        m_in = 0;
      end
    end
  endfunction

  // Compare process: outputs at each negedge reflect the last
  // posedge; the model is then advanced for the coming edge.
  initial begin
    bit     a;
    bit     d;
    m_res_t r;
    forever begin
      @(negedge clk);
      if (srst) begin
        beat_q.delete();
        res_q.delete();
        m_in = 0; e_done = 0; e_len = 0;
        e_ord = 0; e_frm = 0; e_pkt = 0; e_err = 0;
        rdy_ok = 0;
      end else begin
        chk("src_valid", longint'(src_valid_o),
            longint'(beat_q.size() != 0));
        chk("snk_ready", longint'(snk_ready_o),
            longint'(rdy_ok && beat_q.size() < 2));
        if (beat_q.size() != 0)
          chk("src_beat",
              longint'({src_startofpacket_o,
                        src_endofpacket_o, src_data_o}),
              longint'(beat_q[0]));
        chk("pkt_done", longint'(pkt_done_o), longint'(e_done));
        chk("pkt_len", longint'(pkt_len_o), longint'(e_len));
        chk("order_err", longint'(order_err_o), longint'(e_ord));
        chk("framing_err", longint'(framing_err_o),
            longint'(e_frm));
        chk("pkt_cnt", longint'(pkt_cnt_o), e_pkt);
        chk("err_cnt", longint'(err_cnt_o), e_err);
        a = snk_valid_i && snk_ready_o;
        d = src_valid_o && src_ready_i;
        m_stray = 0;
        if (d && beat_q.size() != 0) begin
          void'(beat_q.pop_front());
          dlv_total++;
        end
        if (a) begin
          beat_q.push_back({snk_startofpacket_i,
                            snk_endofpacket_i, snk_data_i});
          acc_total++;
          m_beat(int'(snk_data_i), snk_startofpacket_i,
                 snk_endofpacket_i);
        end
        e_err += m_stray;
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          e_done = 1; e_len = r.len;
          e_ord = r.ord; e_frm = r.frm;
          if (e_pkt < 64'hFFFF_FFFF) e_pkt++;
          if (r.ord || r.frm) e_err++;
        end else begin
          e_done = 0;
        end
        if (e_err > 65535) e_err = 65535;
        rdy_ok = 1;
      end
    end
  end

  // ---------------- stimulus ----------------

  int rdy_mode = 1;

  initial begin
    src_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       src_ready_i = 1'b0;
        1:       src_ready_i = 1'b1;
        default: src_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit s,
                      input bit e);
    bit got = 0;
    snk_data_i          = d;
    snk_startofpacket_i = s;
    snk_endofpacket_i   = e;
    snk_valid_i         = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (snk_ready_o) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("send_ready", longint'(got), 1);
    step();
    snk_valid_i         = 1'b0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
  endtask

  task automatic expect_done(input string nm, input int lim,
                             input int len, input bit ord,
                             input bit frm, input longint pc,
                             input longint ec);
    bit got = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (pkt_done_o) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_seen"}, longint'(got), 1);
    if (got) begin
      chk({nm, "_len"}, longint'(pkt_len_o), longint'(len));
      chk({nm, "_ord"}, longint'(order_err_o), longint'(ord));
      chk({nm, "_frm"}, longint'(framing_err_o), longint'(frm));
      chk({nm, "_pcnt"}, longint'(pkt_cnt_o), pc);
      chk({nm, "_ecnt"}, longint'(err_cnt_o), ec);
    end
    step();
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, "_outs"},
        longint'({snk_ready_o, src_valid_o, src_data_o,
                  src_startofpacket_o, src_endofpacket_o,
                  pkt_done_o, pkt_len_o, order_err_o,
                  framing_err_o}), 0);
    chk({nm, "_cnts"}, longint'({pkt_cnt_o, err_cnt_o}), 0);
  endtask

  task automatic do_reset();
    step();
    srst = 1'b1;
    #1;
    zero_chk("rst");
    @(posedge clk);
    step();
    srst = 1'b0;
    @(negedge clk);
    chk("rdy_pre", longint'(snk_ready_o), 0);
    @(negedge clk);
    chk("rdy_post", longint'(snk_ready_o), 1);
    step();
  endtask

  bit bp_done;

  initial begin
    int acc0;
    int dlv0;
    int plen;
    int base;
    int x;
    bit s;
    bit e;
    srst                = 1'b1;
    snk_data_i          = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
    snk_valid_i         = 1'b0;
    repeat (3) @(posedge clk);

    // sorted packet
    do_reset();
    send(8'd1, 1, 0); send(8'd2, 0, 0); send(8'd2, 0, 0);
    send(8'd5, 0, 0); send(8'd9, 0, 1);
    expect_done("sorted", 20, 5, 0, 0, 1, 0);

    // descending pair
    do_reset();
    send(8'd3, 1, 0); send(8'd7, 0, 0); send(8'd4, 0, 1);
    expect_done("desc", 20, 3, 1, 0, 1, 1);

    // stray beat then single-beat packet
    do_reset();
    send(8'h11, 0, 0);
    @(negedge clk);
    chk("stray_err", longint'(err_cnt_o), 1);
    chk("stray_nodone", longint'(pkt_done_o), 0);
    step();
    send(8'h22, 1, 1);
    expect_done("single", 20, 1, 0, 0, 1, 1);

    // SOP abort followed by single-beat packet
    do_reset();
    send(8'h10, 1, 0); send(8'h20, 0, 0); send(8'h30, 1, 1);
    expect_done("abort1", 20, 2, 0, 1, 1, 1);
    expect_done("abort2", 1, 1, 0, 0, 2, 1);

    // backpressure
    do_reset();
    rdy_mode = 0;
    step();
    acc0 = acc_total;
    dlv0 = dlv_total;
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(DW'(i * 3), i == 0, i == 9);
        bp_done = 1;
      end
    join_none
    repeat (12) @(negedge clk);
    chk("bp_acc", longint'(acc_total - acc0), 2);
    chk("bp_rdy", longint'(snk_ready_o), 0);
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #2;
      if (bp_done) break;
    end
    chk("bp_finish", longint'(bp_done), 1);
    expect_done("bp", 20, 10, 0, 0, 1, 0);
    repeat (4) step();
    chk("bp_dlv", longint'(dlv_total - dlv0), 10);

    // random traffic, random source ready
    do_reset();
    rdy_mode = 2;
    for (int p = 0; p < 400; p++) begin
      plen = int'($urandom_range(1, 8));
      base = int'($urandom_range(0, 200));
      for (int i = 0; i < plen; i++) begin
        s = (i == 0) ? ($urandom_range(0, 9) != 0)
                     : ($urandom_range(0, 19) == 0);
        e = (i == plen - 1) ? ($urandom_range(0, 9) != 0)
                            : ($urandom_range(0, 29) == 0);
        base = base + int'($urandom_range(0, 5));
        x = ($urandom_range(0, 9) == 0)
            ? int'($urandom_range(0, 255)) : base;
        send(DW'(x), s, e);
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) step();
      end
    end
    rdy_mode = 1;
    repeat (10) step();

    // length limit
    do_reset();
    for (int i = 0; i < 258; i++)
      send(DW'(i >> 1), i == 0, i == 257);
    expect_done("maxlen", 20, 256, 0, 1, 1, 1);

    // async reset mid-packet
    do_reset();
    send(8'd1, 1, 0); send(8'd2, 0, 0); send(8'd3, 0, 0);
    #2;
    srst = 1'b1;
    #1;
    zero_chk("async");
    @(posedge clk);
    step();
    srst = 1'b0;
    @(negedge clk);
    chk("arst_rdy_pre", longint'(snk_ready_o), 0);
    @(negedge clk);
    chk("arst_rdy_post", longint'(snk_ready_o), 1);
    step();
    send(8'd10, 1, 0); send(8'd20, 0, 0);
    send(8'd30, 0, 0); send(8'd40, 0, 1);
    expect_done("post_rst", 20, 4, 0, 0, 1, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run still active, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
